// File: rtl/unified_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter_if
//   Bundles every bus signal of the unified memory arbiter: the IF requester,
//   the MEM requester, the shared single-ported memory port and the datapath
//   address-mux select / stall outputs.
//
//   Modports
//     slave  : the arbiter's view (requests and port_ack/port_rdata in,
//              grants, port drive, ready/rdata, addr_sel and stalls out)
//     master : the environment's view (pipeline stages plus memory model)
//
//   Signals (W = WORD_LENGTH)
//     if_req, if_addr[W]                          IF read request / address
//     if_ready, if_rdata[W]                       IF completion pulse / data
//     mem_req, mem_we, mem_addr[W], mem_wdata[W]  MEM access request
//     mem_ready, mem_rdata[W]                     MEM completion pulse / data
//     port_req, port_we, port_addr[W], port_wdata[W]  memory-port drive
//     port_ack, port_rdata[W]                     memory-port completion
//     addr_sel                                    0 = IF addr, 1 = MEM addr
//     if_stall, mem_stall                         requester stall indications
// ----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   if_req;
    logic [WORD_LENGTH-1:0] if_addr;
    logic                   if_ready;
    logic [WORD_LENGTH-1:0] if_rdata;

    logic                   mem_req;
    logic                   mem_we;
    logic [WORD_LENGTH-1:0] mem_addr;
    logic [WORD_LENGTH-1:0] mem_wdata;
    logic                   mem_ready;
    logic [WORD_LENGTH-1:0] mem_rdata;

    logic                   port_req;
    logic                   port_we;
    logic [WORD_LENGTH-1:0] port_addr;
    logic [WORD_LENGTH-1:0] port_wdata;
    logic                   port_ack;
    logic [WORD_LENGTH-1:0] port_rdata;

    logic                   addr_sel;
    logic                   if_stall;
    logic                   mem_stall;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        output port_req, port_we, port_addr, port_wdata,
        input  port_ack, port_rdata,
        output addr_sel, if_stall, mem_stall
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        input  port_req, port_we, port_addr, port_wdata,
        output port_ack, port_rdata,
        input  addr_sel, if_stall, mem_stall
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   stage and the data-memory stage. MEM wins ties, except that after
//   STARVE_LIMIT consecutive lost ties IF is granted. The winner's address,
//   write enable and write data are latched on the grant edge and held on the
//   memory port until port_ack; the returned data is registered into the
//   winner's rdata register and its ready pulses for exactly one cycle
//   (the DONE state). Also drives the datapath address-mux select.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : unified_mem_arbiter_if.slave (requests, memory port, ready,
//              rdata, addr_sel, stalls)
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int WORD_LENGTH  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    unified_mem_arbiter_if.slave         bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_starve_cnt;
    logic [CNT_W-1:0]       w_starve_nxt;
    logic                   w_grant_if;
    logic                   w_grant_mem;
    logic                   w_done_if;
    logic                   w_done_mem;

    logic                   r_port_we;
    logic [WORD_LENGTH-1:0] r_port_addr;
    logic [WORD_LENGTH-1:0] r_port_wdata;
    logic                   r_if_ready;
    logic                   r_mem_ready;
    logic [WORD_LENGTH-1:0] r_if_rdata;
    logic [WORD_LENGTH-1:0] r_mem_rdata;

    // Next-state / arbitration
    always_comb begin
        w_next_state = r_state;
        w_starve_nxt = r_starve_cnt;
        w_grant_if   = 1'b0;
        w_grant_mem  = 1'b0;
        w_done_if    = 1'b0;
        w_done_mem   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.if_req && bus.mem_req) begin
                    // Tie: MEM keeps the pipeline moving unless IF has
                    // already lost STARVE_LIMIT ties in a row.
                    if (r_starve_cnt == LIMIT) begin
                        w_grant_if = 1'b1;
                    end else begin
                        w_grant_mem  = 1'b1;
                        w_starve_nxt = r_starve_cnt + CNT_W'(1);
                    end
                end else if (bus.if_req) begin
                    w_grant_if = 1'b1;
                end else if (bus.mem_req) begin
                    w_grant_mem = 1'b1;
                end

                if (w_grant_if) begin
                    w_next_state = GNT_IF;
                    w_starve_nxt = '0;
                end else if (w_grant_mem) begin
                    w_next_state = GNT_MEM;
                end
            end
            GNT_IF: begin
                if (bus.port_ack) begin
                    w_done_if    = 1'b1;
                    w_next_state = DONE;
                end
            end
            GNT_MEM: begin
                if (bus.port_ack) begin
                    w_done_mem   = 1'b1;
                    w_next_state = DONE;
                end
            end
            // DONE ignores requests so a requester dropping its request
            // after seeing ready is never granted a second time.
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, counter, latched port drive and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_port_we    <= 1'b0;
            r_port_addr  <= '0;
            r_port_wdata <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_starve_nxt;
            r_if_ready   <= w_done_if;
            r_mem_ready  <= w_done_mem;

            if (w_grant_if) begin
                r_port_addr  <= bus.if_addr;
                r_port_we    <= 1'b0;
                r_port_wdata <= '0;
            end else if (w_grant_mem) begin
                r_port_addr  <= bus.mem_addr;
                r_port_we    <= bus.mem_we;
                r_port_wdata <= bus.mem_wdata;
            end

            if (w_done_if) begin
                r_if_rdata <= bus.port_rdata;
            end
            if (w_done_mem) begin
                r_mem_rdata <= bus.port_rdata;
            end
        end
    end

    // port_req and addr_sel decode straight from the state register so an
    // asynchronous reset drops them immediately.
    assign bus.port_req   = (r_state == GNT_IF) || (r_state == GNT_MEM);
    assign bus.addr_sel   = (r_state == GNT_MEM);
    assign bus.port_we    = r_port_we;
    assign bus.port_addr  = r_port_addr;
    assign bus.port_wdata = r_port_wdata;

    assign bus.if_ready   = r_if_ready;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.mem_ready  = r_mem_ready;
    assign bus.mem_rdata  = r_mem_rdata;

    assign bus.if_stall   = bus.if_req  & ~r_if_ready;
    assign bus.mem_stall  = bus.mem_req & ~r_mem_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//   Directed bench for unified_mem_arbiter (WORD_LENGTH=32, STARVE_LIMIT=4).
//   Inputs change and outputs are observed 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    unified_mem_arbiter_if #(.WORD_LENGTH(32)) bus ();

    unified_mem_arbiter #(
        .WORD_LENGTH (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.port_ack   = 1'b0;
        bus.port_rdata = '0;

        // ---------------- reset values ----------------
        step();
        step();
        chk("rst_port_req",   32'(bus.port_req),   32'd0);
        chk("rst_port_we",    32'(bus.port_we),    32'd0);
        chk("rst_port_addr",  bus.port_addr,       32'd0);
        chk("rst_port_wdata", bus.port_wdata,      32'd0);
        chk("rst_if_ready",   32'(bus.if_ready),   32'd0);
        chk("rst_mem_ready",  32'(bus.mem_ready),  32'd0);
        chk("rst_if_rdata",   bus.if_rdata,        32'd0);
        chk("rst_mem_rdata",  bus.mem_rdata,       32'd0);
        chk("rst_addr_sel",   32'(bus.addr_sel),   32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- lone IF read, ack on first port_req cycle ----------------
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        step();                                    // GNT_IF
        chk("if_port_req",  32'(bus.port_req),  32'd1);
        chk("if_port_addr", bus.port_addr,      32'h40);
        chk("if_port_we",   32'(bus.port_we),   32'd0);
        chk("if_addr_sel",  32'(bus.addr_sel),  32'd0);
        chk("if_stall",     32'(bus.if_stall),  32'd1);
        chk("if_ready_early", 32'(bus.if_ready), 32'd0);
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'hDEADBEEF;
        step();                                    // DONE
        chk("if_ready",      32'(bus.if_ready),  32'd1);
        chk("if_rdata",      bus.if_rdata,       32'hDEADBEEF);
        chk("if_done_req",   32'(bus.port_req),  32'd0);
        chk("if_done_sel",   32'(bus.addr_sel),  32'd0);
        chk("if_done_mrdy",  32'(bus.mem_ready), 32'd0);
        chk("if_stall_done", 32'(bus.if_stall),  32'd0);
        bus.if_req   = 1'b0;
        bus.port_ack = 1'b0;
        step();                                    // IDLE
        chk("if_ready_width", 32'(bus.if_ready), 32'd0);
        chk("if_rdata_hold",  bus.if_rdata,      32'hDEADBEEF);

        // ---------------- lone MEM write, ack after 3 wait cycles ----------------
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h100;
        bus.mem_wdata = 32'h12345678;
        step();                                    // GNT_MEM cycle 1
        chk("mw_port_req",   32'(bus.port_req),  32'd1);
        chk("mw_port_we",    32'(bus.port_we),   32'd1);
        chk("mw_port_addr",  bus.port_addr,      32'h100);
        chk("mw_port_wdata", bus.port_wdata,     32'h12345678);
        chk("mw_sel_c1",     32'(bus.addr_sel),  32'd1);
        chk("mw_stall_c1",   32'(bus.mem_stall), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            step();                                // GNT_MEM cycles 2..4
            chk("mw_sel_wait",   32'(bus.addr_sel),  32'd1);
            chk("mw_req_wait",   32'(bus.port_req),  32'd1);
            chk("mw_stall_wait", 32'(bus.mem_stall), 32'd1);
            chk("mw_rdy_wait",   32'(bus.mem_ready), 32'd0);
            chk("mw_wdata_hold", bus.port_wdata,     32'h12345678);
        end
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'hCAFE0000;
        step();                                    // DONE (t+5)
        chk("mw_ready",     32'(bus.mem_ready), 32'd1);
        chk("mw_stall_end", 32'(bus.mem_stall), 32'd0);
        chk("mw_sel_done",  32'(bus.addr_sel),  32'd0);
        chk("mw_if_ready",  32'(bus.if_ready),  32'd0);
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.port_ack = 1'b0;
        step();                                    // IDLE

        // ---------------- simultaneous requests ----------------
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h80;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h200;
        step();                                    // GNT_MEM
        chk("tie_sel_mem",  32'(bus.addr_sel), 32'd1);
        chk("tie_addr_mem", bus.port_addr,     32'h200);
        chk("tie_we_mem",   32'(bus.port_we),  32'd0);
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'h11111111;
        step();                                    // DONE
        chk("tie_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("tie_if_ready0", 32'(bus.if_ready),  32'd0);
        chk("tie_mem_rdata", bus.mem_rdata,      32'h11111111);
        bus.mem_req  = 1'b0;
        bus.port_ack = 1'b0;
        step();                                    // IDLE
        chk("tie_idle_req", 32'(bus.port_req), 32'd0);
        step();                                    // GNT_IF
        chk("tie_sel_if",  32'(bus.addr_sel), 32'd0);
        chk("tie_addr_if", bus.port_addr,     32'h80);
        chk("tie_req_if",  32'(bus.port_req), 32'd1);
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'h22222222;
        step();                                    // DONE
        chk("tie_if_ready",   32'(bus.if_ready), 32'd1);
        chk("tie_if_rdata",   bus.if_rdata,      32'h22222222);
        chk("tie_mem_rdata2", bus.mem_rdata,     32'h11111111);
        bus.if_req   = 1'b0;
        bus.port_ack = 1'b0;
        step();                                    // IDLE

        // ---------------- starvation bound ----------------
        // Ties 0..3 go to MEM, tie 4 to IF, tie 5 back to MEM.
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'hA0;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'hB0;
        for (int k = 0; k < 6; k++) begin
            step();                                // GNT_x
            chk("stv_sel",  32'(bus.addr_sel),  (k == 4) ? 32'd0 : 32'd1);
            chk("stv_addr", bus.port_addr,      (k == 4) ? 32'hA0 : 32'hB0);
            bus.port_ack   = 1'b1;
            bus.port_rdata = 32'hA0000000 + 32'(k);
            step();                                // DONE
            chk("stv_if_rdy",  32'(bus.if_ready),  (k == 4) ? 32'd1 : 32'd0);
            chk("stv_mem_rdy", 32'(bus.mem_ready), (k == 4) ? 32'd0 : 32'd1);
            bus.port_ack = 1'b0;
            step();                                // IDLE
        end
        chk("stv_if_rdata",  bus.if_rdata,  32'hA0000004);
        chk("stv_mem_rdata", bus.mem_rdata, 32'hA0000005);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;

        // ---------------- spurious ack in IDLE ----------------
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'hBAD0BAD0;
        step();
        step();
        chk("sp_idle_req",     32'(bus.port_req),  32'd0);
        chk("sp_idle_ifrdy",   32'(bus.if_ready),  32'd0);
        chk("sp_idle_memrdy",  32'(bus.mem_ready), 32'd0);
        chk("sp_idle_ifrdata", bus.if_rdata,       32'hA0000004);
        chk("sp_idle_mrdata",  bus.mem_rdata,      32'hA0000005);
        bus.port_ack = 1'b0;

        // ---------------- request held through DONE ----------------
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h300;
        step();                                    // GNT_MEM
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'h33333333;
        step();                                    // DONE, mem_req still high
        chk("hold_ready", 32'(bus.mem_ready), 32'd1);
        bus.port_rdata = 32'h44444444;             // ack stays high in DONE
        step();                                    // IDLE, no re-grant
        chk("hold_no_regrant", 32'(bus.port_req),  32'd0);
        chk("hold_rdy_clear",  32'(bus.mem_ready), 32'd0);
        chk("hold_rdata",      bus.mem_rdata,      32'h33333333);
        bus.mem_req  = 1'b0;
        bus.port_ack = 1'b0;
        step();
        chk("hold_idle_req", 32'(bus.port_req), 32'd0);

        // ---------------- reset mid-GNT_MEM ----------------
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h500;
        bus.mem_wdata = 32'h55;
        step();                                    // GNT_MEM, ack low
        chk("mr_req_before", 32'(bus.port_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_req_async",  32'(bus.port_req),  32'd0);
        chk("mr_sel",        32'(bus.addr_sel),  32'd0);
        chk("mr_port_addr",  bus.port_addr,      32'd0);
        chk("mr_port_we",    32'(bus.port_we),   32'd0);
        chk("mr_port_wdata", bus.port_wdata,     32'd0);
        chk("mr_if_rdata",   bus.if_rdata,       32'd0);
        chk("mr_mem_rdata",  bus.mem_rdata,      32'd0);
        chk("mr_if_ready",   32'(bus.if_ready),  32'd0);
        chk("mr_mem_ready",  32'(bus.mem_ready), 32'd0);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h60;
        step();                                    // GNT_IF
        chk("mr_if_grant", 32'(bus.port_req), 32'd1);
        chk("mr_if_addr",  bus.port_addr,     32'h60);
        chk("mr_if_sel",   32'(bus.addr_sel), 32'd0);
        bus.port_ack   = 1'b1;
        bus.port_rdata = 32'h77;
        step();                                    // DONE
        chk("mr_if_ready", 32'(bus.if_ready), 32'd1);
        chk("mr_if_data",  bus.if_rdata,      32'h77);
        bus.if_req   = 1'b0;
        bus.port_ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
